median_window_ctrl: RTL and testbench
=====================================

# median_window_ctrl

Streaming controller that feeds the 9-input approximate median filter core (`cf`). It accepts a raster-order 8-bit pixel stream and builds a 3x3 neighbourhood with two line buffers and a 3x3 shift window. It presents the nine taps and the mode select to the core, then registers the core result onto a valid/ready output stream. It sits between the pixel source and the downstream frame sink, and sequences one frame per `start`.

## Interface
- `IMG_W`, 64: frame width in pixels, at least 3.
- `IMG_H`, 64: frame height in lines, at least 3.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a frame when idle.
- `mode`  in  2  filter mode; sampled at `start`.
- `pix_in`  in  8  input pixel.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  controller accepts `pix_in` this cycle.
- `w0`..`w8`  out  8 each  window taps to the core, row-major. `w0` is (r-1,c-1), `w4` is the centre, `w8` is (r+1,c+1).
- `sel`  out  2  mode to the core's `s` input.
- `core_y`  in  8  combinational core result.
- `out_pix`  out  8  filtered pixel.
- `out_valid`  out  1  `out_pix` is valid.
- `out_ready`  in  1  sink accepts `out_pix`.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse marking the end of a frame.

## Operation
- **Reset.** On reset the state is IDLE. All outputs, counters, the window registers and `sel` are cleared to 0. Line-buffer contents are don't-care.
- **IDLE.** `pix_ready` is 0.
  - `start` latches `mode` into `sel` and clears `row` and `col`.
  - The state moves to RUN and `busy` goes to 1.
- **RUN.** `pix_ready` = `!out_valid || out_ready`.
  - A pixel is accepted when `pix_valid && pix_ready`.
  - Each accept shifts the window left. The new column is `{lb0[col], lb1[col], pix_in}`, top to bottom.
  - Each accept writes `lb0[col] <= lb1[col]` and `lb1[col] <= pix_in`.
  - `col` then increments and wraps at IMG_W-1. On the wrap, `row` increments.
- **Output generation.**
  - Accepting pixel (r,c) with r≥2 and c≥2 completes the window centred at (r-1,c-1).
  - On the next edge, `out_pix <= core_y` and `out_valid <= 1`.
  - `out_valid` clears on an `out_valid && out_ready` handshake unless a new result is loaded in the same cycle.
- **Output count.** A frame produces (IMG_H-2)(IMG_W-2) outputs, in raster order. Taps that straddle a row wrap are never emitted.
- **End of frame.** The state moves to DRAIN after pixel (IMG_H-1, IMG_W-1) is accepted.
  - In DRAIN, `pix_ready` is 0.
  - When the last output handshakes, `done` pulses for one cycle, `busy` drops, and the state returns to IDLE.
- **Boundary rules.**
  - `start` while `busy` is ignored.
  - A change on `mode` mid-frame has no effect; `sel` is held for the whole frame.
  - `pix_valid` in IDLE or DRAIN is ignored.
  - An accept and an output handshake in the same cycle are both honoured, with no bubble.

## Timing
- Pixel-to-output latency is 1 clock from the accepting edge to `out_valid`.
- Sustained throughput is 1 pixel per clock with `out_ready` held high.
- `out_pix` is stable while `out_valid && !out_ready`.
- An `rst_n` assertion mid-frame aborts immediately with the reset values above. No `done` is produced.

## Configuration
- `BORDER_PASS_EN` defined:
  - All IMG_H·IMG_W pixels are emitted in raster order.
  - Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) are emitted as the raw centre value, bypassing `core_y`.
  - Output (r,c) is produced on the accept of pixel (r+1,c+1), clamped to the frame end.
  - A FLUSH state follows the last accept and emits the remaining IMG_W+1 outputs, one per handshake, with `pix_ready` at 0.
  - `done` pulses after output (IMG_H-1, IMG_W-1).
- `BORDER_PASS_EN` undefined: interior-only behaviour as above. There is no FLUSH state.

## Test plan
Bench settings for all scenarios: IMG_W=IMG_H=4, `core_y` driven by a true-median model, input is the ramp 0..15.
- **Reset.** Assert `rst_n`=0 → `out_valid`, `pix_ready`, `busy`, `done` and `w0`..`w8` are all 0.
- **Basic frame.** `start` with `mode`=2, `out_ready`=1, `pix_valid`=1 → `out_pix` sequence is 5, 6, 9, 10. `sel`=2 throughout. `done` pulses once after the fourth output.
- **Backpressure.** Hold `out_ready` low for 3 cycles on the first output → `out_pix` holds 5 and `pix_ready` is 0. After release the sequence is still 5, 6, 9, 10.
- **Ignored inputs.** Change `mode` to 1 and pulse `start` mid-frame → `sel` stays 2 and the frame completes unchanged.
- **Reset mid-frame.** Assert `rst_n` low after 7 accepts → no output and no `done`. A fresh frame afterwards yields 5, 6, 9, 10.
- **Border pass.** With `BORDER_PASS_EN` → 16 outputs equal to 0..15 in order. `done` pulses after the 16th output.

Source files
------------

// File: rtl/median_window_ctrl.sv
// median_window_ctrl: line buffers, 3x3 window and output register for the median core.
// Optional macro BORDER_PASS_EN: emit border pixels raw so the whole frame is output.
module median_window_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] w0,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [7:0] w5,
    output logic [7:0] w6,
    output logic [7:0] w7,
    output logic [7:0] w8,
    output logic [1:0] sel,
    input  logic [7:0] core_y,
    output logic [7:0] out_pix,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 2);

`ifdef BORDER_PASS_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
`endif

    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic [7:0]    lb0_q [IMG_W];
    logic [7:0]    lb1_q [IMG_W];
    logic          load_q, load_d;
    logic [7:0]    out_pix_q, out_pix_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          slot_free, accept, shift, emit, use_raw;
    logic          col_last, row_last;
`ifdef BORDER_PASS_EN
    logic          raw_q, raw_d;
    logic [CW-1:0] ocol_q, ocol_d;
    logic [RW-1:0] orow_q, orow_d;
    logic          phantom;
`endif

    always_comb begin
        slot_free = !out_valid_q || out_ready;
        accept    = (state_q == S_RUN) && slot_free && pix_valid;
        col_last  = col_q == CW'(IMG_W - 1);
        row_last  = row_q == RW'(IMG_H - 1);
`ifdef BORDER_PASS_EN
        // FLUSH keeps the window moving with no pixel so the last row drains out
        phantom = (state_q == S_FLUSH) && slot_free;
        shift   = accept || phantom;
        emit    = phantom || (accept && (row_q >= RW'(2) ||
                  (row_q == RW'(1) && col_q != '0)));
        use_raw = raw_q;
`else
        shift   = accept;
        emit    = accept && row_q >= RW'(2) && col_q >= CW'(2);
        use_raw = 1'b0;
`endif

        state_d     = state_q;
        sel_d       = sel_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        load_d      = load_q;
        out_pix_d   = out_pix_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef BORDER_PASS_EN
        raw_d  = raw_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
`endif

        // The window completed on the previous accept is evaluated by the core now
        if (load_q && slot_free) begin
            out_pix_d   = use_raw ? win_q[4] : core_y;
            out_valid_d = 1'b1;
            load_d      = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (shift) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = lb0_q[col_q];
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = lb1_q[col_q];
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix_in;
            col_d    = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_q + 1'b1;
            end
        end

        if (emit) begin
            load_d = 1'b1;
`ifdef BORDER_PASS_EN
            raw_d  = orow_q == '0 || orow_q == RW'(IMG_H - 1) ||
                     ocol_q == '0 || ocol_q == CW'(IMG_W - 1);
            ocol_d = (ocol_q == CW'(IMG_W - 1)) ? '0 : ocol_q + 1'b1;
            if (ocol_q == CW'(IMG_W - 1)) begin
                orow_d = orow_q + 1'b1;
            end
`endif
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = mode;
                    row_d   = '0;
                    col_d   = '0;
                    load_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
`ifdef BORDER_PASS_EN
                    orow_d = '0;
                    ocol_d = '0;
`endif
                end
            end
            S_RUN: begin
                if (accept && row_last && col_last) begin
`ifdef BORDER_PASS_EN
                    state_d = S_FLUSH;
`else
                    state_d = S_DRAIN;
`endif
                end
            end
`ifdef BORDER_PASS_EN
            S_FLUSH: begin
                if (phantom && orow_q == RW'(IMG_H - 1) &&
                    ocol_q == CW'(IMG_W - 1)) begin
                    state_d = S_DRAIN;
                end
            end
`endif
            S_DRAIN: begin
                if (!load_q && out_valid_q && out_ready) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            load_q      <= 1'b0;
            out_pix_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
`ifdef BORDER_PASS_EN
            raw_q  <= 1'b0;
            ocol_q <= '0;
            orow_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            col_q       <= col_d;
            row_q       <= row_d;
            load_q      <= load_d;
            out_pix_q   <= out_pix_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            win_q       <= win_d;
`ifdef BORDER_PASS_EN
            raw_q  <= raw_d;
            ocol_q <= ocol_d;
            orow_q <= orow_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= pix_in;
        end
    end

    assign pix_ready = (state_q == S_RUN) && slot_free;
    assign sel       = sel_q;
    assign out_pix   = out_pix_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign w0        = win_q[0];
    assign w1        = win_q[1];
    assign w2        = win_q[2];
    assign w3        = win_q[3];
    assign w4        = win_q[4];
    assign w5        = win_q[5];
    assign w6        = win_q[6];
    assign w7        = win_q[7];
    assign w8        = win_q[8];

endmodule

// File: tb/tb_median_window_ctrl.sv
// tb_median_window_ctrl: 4x4 frames through the controller with a true-median core.
// Expected pixels come from a per-frame neighbourhood model of the input image.
module tb_median_window_ctrl;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n, start, pix_valid, pix_ready;
    logic       out_valid, out_ready, busy, done;
    logic [1:0] mode, sel;
    logic [7:0] pix_in, core_y, out_pix;
    logic [7:0] w [9];

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] expq [$];

    always #5 clk = ~clk;

    median_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]), .w4(w[4]),
        .w5(w[5]), .w6(w[6]), .w7(w[7]), .w8(w[8]),
        .sel(sel), .core_y(core_y), .out_pix(out_pix),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    function automatic logic [7:0] med9(input logic [7:0] v [9]);
        logic [7:0] s [9];
        logic [7:0] t;
        s = v;
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 8 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
            end
        end
        return s[4];
    endfunction

    always_comb begin
        core_y = med9(w);
    end

    task automatic chk(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic void build_exp(input logic [7:0] img [N]);
        logic [7:0] nb [9];
        expq.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
                    for (int k = 0; k < 9; k++) begin
                        nb[k] = img[(r + k / 3 - 1) * W + c + k % 3 - 1];
                    end
                    expq.push_back(med9(nb));
                end
`ifdef BORDER_PASS_EN
                else begin
                    expq.push_back(img[r * W + c]);
                end
`endif
            end
        end
    endfunction

    task automatic reset_checks();
        chk("rst_ov", int'(out_valid), 0);
        chk("rst_rdy", int'(pix_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sel", int'(sel), 0);
        for (int i = 0; i < 9; i++) begin
            chk("rst_tap", int'(w[i]), 0);
        end
    endtask

    task automatic run_frame(input logic [1:0] m, input bit ramp, input int pv,
                             input int orp, input bit noise, input bit stall_first,
                             input int abort_at);
        logic [7:0] img [N];
        logic [7:0] prev_pix;
        int         acc_cyc [N];
        int         idx, cyc, stall, first_out, src;
        bit         hs_last, prev_hold, fin;
        for (int i = 0; i < N; i++) begin
            img[i] = ramp ? 8'(i) : 8'($urandom);
        end
        build_exp(img);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_sel", int'(sel), int'(m));
        idx = 0; cyc = 0; stall = 0; first_out = -1;
        hs_last = 0; prev_hold = 0; fin = 0; prev_pix = '0;
        while (!fin) begin
            if (abort_at > 0 && idx == abort_at) begin
                #1 rst_n = 1'b0;
                pix_valid = 1'b0;
                #1;
                reset_checks();
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_done", int'(done), 0);
                    chk("abort_ov", int'(out_valid), 0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (out_valid && first_out < 0) first_out = cyc;
            pix_valid = int'($urandom_range(99)) < pv;
            pix_in    = (idx < N) ? img[idx] : 8'($urandom);
            out_ready = int'($urandom_range(99)) < orp;
            if (stall_first && first_out == cyc) stall = 3;
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end
            start = noise && !hs_last && ($urandom_range(3) == 0);
            if (noise) mode = 2'($urandom);
            #1;
            if (hs_last) begin
                chk("done_pulse", int'(done), 1);
                chk("done_busy", int'(busy), 0);
                chk("done_ov", int'(out_valid), 0);
                fin = 1;
            end else begin
                chk("done_early", int'(done), 0);
                chk("busy", int'(busy), 1);
                chk("sel_hold", int'(sel), int'(m));
                chk("pix_ready", int'(pix_ready),
                    int'(idx < N && (!out_valid || out_ready)));
                if (prev_hold) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_pix", int'(out_pix), int'(prev_pix));
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        chk("extra_out", 1, 0);
                    end else begin
                        chk("out_pix", int'(out_pix), int'(expq.pop_front()));
                        if (expq.size() == 0) hs_last = 1;
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_pix  = out_pix;
                if (pix_valid && pix_ready) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                end
            end
            start = 1'b0;
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                chk("timeout", 0, 1);
                fin = 1;
            end
        end
        pix_valid = 1'b0;
`ifdef BORDER_PASS_EN
        src = W + 1;
`else
        src = 2 * W + 2;
`endif
        if (pv == 100 && orp == 100 && !stall_first) begin
            chk("latency", first_out - acc_cyc[src], 2);
            chk("frame_cycles", cyc, N + 3);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 2'd0;
        pix_in = '0; pix_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks();
        rst_n = 1'b1;
        @(negedge clk);
        pix_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("idle_ready", int'(pix_ready), 0);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ov", int'(out_valid), 0);
        pix_valid = 1'b0;

        run_frame(2'd2, 1, 100, 100, 0, 0, 0);
        run_frame(2'd2, 1, 100, 100, 0, 1, 0);
        run_frame(2'd2, 1, 100, 100, 1, 0, 0);
        run_frame(2'd2, 1, 100, 100, 0, 0, 7);
        run_frame(2'd2, 1, 100, 100, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            run_frame(2'($urandom), 0, 30 + 10 * k, 90 - 10 * k, 1, k[0], 0);
        end

        pix_valid = 1'b1;
        #1;
        chk("end_ready", int'(pix_ready), 0);
        @(negedge clk);
        chk("end_busy", int'(busy), 0);
        pix_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
